// File: rtl/rr_priority_encoder_if.sv
// rr_priority_encoder_if: request/result handshake bundle for rr_priority_encoder
interface rr_priority_encoder_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
);
  logic [WIDTH-1:0] req_i;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] idx_o;
  logic [WIDTH-1:0] onehot_o;
  logic             any_o;
  logic             multi_o;
  modport master (
    output req_i, in_valid, out_ready,
    input  in_ready, out_valid, idx_o, onehot_o, any_o, multi_o
  );
  modport slave (
    input  req_i, in_valid, out_ready,
    output in_ready, out_valid, idx_o, onehot_o, any_o, multi_o
  );
endinterface

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: registered fixed/round-robin priority encoder with valid/ready output stage
module rr_priority_encoder #(
  parameter int WIDTH       = 8,
  parameter int IDX_W       = $clog2(WIDTH),
  parameter int ROUND_ROBIN = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_priority_encoder_if.slave bus
);
  logic [WIDTH-1:0] req, onehot_q;
  logic [IDX_W-1:0] ptr, fix_win, rr_win, win, idx_q;
  logic             any, multi, accept, valid, any_q, multi_q;
  int               j;
  assign req    = bus.req_i;
  assign any    = |req;
  // clearing the lowest set bit leaves something only if two or more were set
  assign multi  = |(req & (req - WIDTH'(1)));
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    fix_win = '0;
    rr_win  = '0;
    j       = 0;
    for (int i = 0; i < WIDTH; i++)
      if (req[IDX_W'(i)]) fix_win = IDX_W'(i);
    // scan distances from far to near so the nearest set bit at/after ptr wins
    for (int k = WIDTH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= WIDTH) j = j - WIDTH;
      if (req[IDX_W'(j)]) rr_win = IDX_W'(j);
    end
  end
  assign win = (ROUND_ROBIN != 0) ? rr_win : fix_win;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid    <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      any_q    <= 1'b0;
      multi_q  <= 1'b0;
      ptr      <= '0;
    end else if (accept) begin
      valid    <= 1'b1;
      idx_q    <= win;
      onehot_q <= any ? (WIDTH'(1) << win) : '0;
      any_q    <= any;
      multi_q  <= multi;
      if (ROUND_ROBIN != 0 && any) ptr <= (win == IDX_W'(WIDTH - 1)) ? '0 : win + IDX_W'(1);
    end else if (bus.out_ready) begin
      valid <= 1'b0;
    end
  assign bus.in_ready  = !valid || bus.out_ready;
  assign bus.out_valid = valid;
  assign bus.idx_o     = idx_q;
  assign bus.onehot_o  = onehot_q;
  assign bus.any_o     = any_q;
  assign bus.multi_o   = multi_q;
endmodule

// File: tb/tb_rr_priority_encoder.sv
// tb_rr_priority_encoder: directed checks of fixed, round-robin and non-power-of-two encoders
module tb_rr_priority_encoder;
  logic clk, rst_n;
  int total = 0;
  int bad = 0;
  rr_priority_encoder_if #(.WIDTH(8)) f ();
  rr_priority_encoder_if #(.WIDTH(8)) r ();
  rr_priority_encoder_if #(.WIDTH(5)) n ();
  rr_priority_encoder #(.WIDTH(8), .ROUND_ROBIN(0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(f));
  rr_priority_encoder #(.WIDTH(8), .ROUND_ROBIN(1)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(r));
  rr_priority_encoder #(.WIDTH(5), .ROUND_ROBIN(1)) u_np  (.clk(clk), .rst_n(rst_n), .bus(n));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] fq  [5] = '{8'h01, 8'h03, 8'h14, 8'h80, 8'h00};
  logic [2:0] fi  [5] = '{3'd0, 3'd1, 3'd4, 3'd7, 3'd0};
  logic [7:0] fo  [5] = '{8'h01, 8'h02, 8'h10, 8'h80, 8'h00};
  logic       fa  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       fm  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [2:0] ri  [4] = '{3'd0, 3'd4, 3'd7, 3'd0};
  logic [7:0] ro  [4] = '{8'h01, 8'h10, 8'h80, 8'h01};
  logic [2:0] ni  [3] = '{3'd0, 3'd4, 3'd0};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_f(input string tag, input logic v, input logic [2:0] idx, input logic [7:0] oh, input logic an, input logic mu);
    chk({tag, ".valid"}, 32'(f.out_valid), 32'(v));
    chk({tag, ".idx"}, 32'(f.idx_o), 32'(idx));
    chk({tag, ".onehot"}, 32'(f.onehot_o), 32'(oh));
    chk({tag, ".any"}, 32'(f.any_o), 32'(an));
    chk({tag, ".multi"}, 32'(f.multi_o), 32'(mu));
  endtask
  task automatic chk_r(input string tag, input logic v, input logic [2:0] idx, input logic [7:0] oh, input logic an, input logic mu);
    chk({tag, ".valid"}, 32'(r.out_valid), 32'(v));
    chk({tag, ".idx"}, 32'(r.idx_o), 32'(idx));
    chk({tag, ".onehot"}, 32'(r.onehot_o), 32'(oh));
    chk({tag, ".any"}, 32'(r.any_o), 32'(an));
    chk({tag, ".multi"}, 32'(r.multi_o), 32'(mu));
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    f.in_valid = 1'b0; f.out_ready = 1'b1; f.req_i = '0;
    r.in_valid = 1'b0; r.out_ready = 1'b1; r.req_i = '0;
    n.in_valid = 1'b0; n.out_ready = 1'b1; n.req_i = '0;
    #12;
    chk_f("rst_fix", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    chk_r("rst_rr", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    #10 rst_n = 1'b1;
    cyc();
    chk("idle_in_ready_fix", 32'(f.in_ready), 32'd1);
    chk("idle_in_ready_rr", 32'(r.in_ready), 32'd1);
    chk_f("idle_fix", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    // fixed priority, back-to-back beats
    f.in_valid = 1'b1;
    f.req_i = fq[0];
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_f($sformatf("fix%0d", i), 1'b1, fi[i], fo[i], fa[i], fm[i]);
      if (i < 4) f.req_i = fq[i+1];
      else f.in_valid = 1'b0;
    end
    cyc();
    chk("fix_drain.valid", 32'(f.out_valid), 32'd0);
    // round-robin with 0x91 held for four beats
    r.in_valid = 1'b1;
    r.req_i = 8'h91;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_r($sformatf("rr%0d", i), 1'b1, ri[i], ro[i], 1'b1, 1'b1);
    end
    r.req_i = 8'h04;
    cyc();
    chk_r("rr_to_ptr3", 1'b1, 3'd2, 8'h04, 1'b1, 1'b0);
    r.req_i = 8'h00;
    cyc();
    chk_r("rr_zero", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
    r.req_i = 8'h09;
    cyc();
    chk_r("rr_after_zero", 1'b1, 3'd3, 8'h08, 1'b1, 1'b1);
    r.in_valid = 1'b0;
    // backpressure on the fixed encoder
    f.in_valid = 1'b1;
    f.req_i = 8'h20;
    cyc();
    chk_f("bp_load", 1'b1, 3'd5, 8'h20, 1'b1, 1'b0);
    f.out_ready = 1'b0;
    f.req_i = 8'h02;
    #1;
    chk("bp_in_ready_low", 32'(f.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_f($sformatf("bp_hold%0d", i), 1'b1, 3'd5, 8'h20, 1'b1, 1'b0);
      chk($sformatf("bp_hold%0d.in_ready", i), 32'(f.in_ready), 32'd0);
    end
    f.out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 32'(f.in_ready), 32'd1);
    cyc();
    f.in_valid = 1'b0;
    chk_f("bp_next", 1'b1, 3'd1, 8'h02, 1'b1, 1'b0);
    cyc();
    chk_f("bp_drain", 1'b0, 3'd1, 8'h02, 1'b1, 1'b0);
    // non-power-of-two width wraps at WIDTH-1
    n.in_valid = 1'b1;
    n.req_i = 5'b10001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("np%0d.idx", i), 32'(n.idx_o), 32'(ni[i]));
    end
    n.in_valid = 1'b0;
    // ptr is 4 here; one more grant at 4 leaves ptr=5 with a pending result
    r.in_valid = 1'b1;
    r.req_i = 8'h10;
    cyc();
    chk_r("mid_load", 1'b1, 3'd4, 8'h10, 1'b1, 1'b0);
    r.in_valid = 1'b0;
    r.out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk_r("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    r.out_ready = 1'b1;
    r.in_valid = 1'b1;
    r.req_i = 8'hFF;
    cyc();
    chk_r("post_rst", 1'b1, 3'd0, 8'h01, 1'b1, 1'b1);
    r.in_valid = 1'b0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- Parametrised, registered N-to-log2(N) priority encoder.
- Successor to the fixed 4:2 encoder: adds width parameterisation, fixed or round-robin priority, zero and multi-hot detection, and a valid/ready output register.
- Used as the index/grant stage in front of request arbiters and interrupt collectors in the combinational-to-sequential datapath blocks.

Parameters:
- WIDTH, 8, number of request lines; must be >= 2.
- IDX_W, $clog2(WIDTH), width of the encoded index.
- ROUND_ROBIN, 0, priority mode: 0 = fixed (highest index wins), 1 = rotating pointer.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  WIDTH  request vector, sampled on an accepted input beat.
- in_valid  input  1  req_i is valid this cycle.
- in_ready  output  1  block can accept req_i this cycle.
- out_valid  output  1  registered result is valid.
- out_ready  input  1  downstream consumes the result this cycle.
- idx_o  output  IDX_W  encoded index of the winning request.
- onehot_o  output  WIDTH  one-hot grant of the winner; all-zero when there is no request.
- any_o  output  1  at least one request bit was set.
- multi_o  output  1  two or more request bits were set.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, idx_o=0, onehot_o=0, any_o=0, multi_o=0.
  - Round-robin pointer ptr=0.
  - in_ready=1 once reset deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Input accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Latency and throughput:
  - On an accept, the result is registered and out_valid=1 on the next edge (1-cycle latency).
  - Full throughput: one result per cycle when out_ready is held high.
- Output holding:
  - If out_valid=1 and out_ready=0, all outputs are held stable and in_ready=0.
  - If a transfer occurs with no accept in the same cycle, out_valid clears to 0 on the next edge and the data outputs keep their last values.
  - A simultaneous transfer and accept loads the new result and keeps out_valid=1.
- Fixed mode (ROUND_ROBIN=0): the winner is the highest set index. This matches the 4:2 encoder convention of Y[3] over Y[0].
- Round-robin mode (ROUND_ROBIN=1):
  - Scan from ptr upward with wrap-around (ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1). The first set bit wins.
  - On an accepted beat with any_o=1, ptr <= (idx+1) mod WIDTH. When idx=WIDTH-1, ptr wraps to 0.
  - ptr is unchanged on a zero request or when no beat is accepted.
- Zero request: the beat is still accepted and produces a result with any_o=0, idx_o=0, onehot_o=0, multi_o=0.
- multi_o is set from the popcount of req_i: 1 when the count is >= 2, else 0. It is independent of mode.
- Invariants (the bench checks these):
  - onehot_o == (any_o ? 1<<idx_o : 0).
  - onehot_o is always a subset of the accepted req_i.
- Reset mid-operation: a pending result is discarded and ptr returns to 0. No partial state survives.
- Non-power-of-two WIDTH: only index values 0..WIDTH-1 are ever produced.

Test Plan:
- Reset and idle: assert rst_n=0 with out_ready=1, then release -> out_valid=0, in_ready=1, all outputs 0; ptr=0 on the first round-robin grant.
- Fixed mode, WIDTH=8, in_valid=1, out_ready=1, req sequence 0x01, 0x03, 0x14, 0x80, 0x00 ->
  - idx 0, 1, 4, 7, 0.
  - any 1, 1, 1, 1, 0.
  - multi 0, 1, 1, 0, 0.
  - Each result appears one cycle after its input, back-to-back with no bubbles.
- Round-robin, WIDTH=8, req held at 0x91 for 4 beats -> idx 0, 4, 7, 0 (ptr 1, 5, 0 (wrap), 1); onehot 0x01, 0x10, 0x80, 0x01.
- Backpressure: accept 0x20, then hold out_ready=0 for 3 cycles while presenting 0x02 ->
  - in_ready=0 and idx_o stays 5 throughout.
  - When out_ready=1: idx 5 transfers and 0x02 is accepted in the same cycle; idx 1 follows on the next cycle.
- Zero request in round-robin mode with ptr=3: req 0x00 -> any_o=0, onehot 0, ptr stays 3; next req 0x09 -> idx 3.
- Reset mid-stream: round-robin mode, ptr=5 with out_valid=1 -> pulse rst_n low asynchronously between edges. Outputs clear immediately; next req 0xFF -> idx 0.
